// File: rtl/date_to_day_number.sv
// Converts an entered date (month digit + BCD day digits) into a day-of-year number.
// Month lengths are accumulated one month per clock after a single validation cycle.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on start
// CHECK | validate latched digits and date, seed accumulator with day
// ACCUM | add one preceding month length per cycle until latched month reached
// DONE  | one-cycle done pulse, result valid
module date_to_day_number #(
  parameter int         MAX_NUMBER = 99,
  parameter logic [3:0] BLANK_CODE = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       leap,
  input  logic [3:0] month,
  input  logic [3:0] day1,
  input  logic [3:0] day0,
  output logic [6:0] number,
  output logic       error,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, DONE} state_t;

  state_t     state;
  logic [3:0] monthLat;
  logic [3:0] day1Lat;
  logic [3:0] day0Lat;
  logic       leapLat;
  logic [7:0] acc;
  logic [2:0] m;

  logic [3:0] tensVal;
  logic [5:0] dayVal;
  logic [4:0] latchedLen;
  logic       monthOk;
  logic       day0Ok;
  logic       day1Ok;
  logic       dateOk;
  logic [4:0] stepLen;
  logic       accTooBig;

  function automatic logic [4:0] monthLength(input logic [2:0] mon, input logic isLeap);
    case (mon)
      3'd1:    monthLength = 5'd31;
      3'd2:    monthLength = isLeap ? 5'd29 : 5'd28;
      3'd3:    monthLength = 5'd31;
      3'd4:    monthLength = 5'd30;
      default: monthLength = 5'd0;
    endcase
  endfunction

  // Blank tens digit reads as zero so single-digit days can be entered.
  always_comb begin
    tensVal    = (day1Lat == BLANK_CODE) ? 4'd0 : day1Lat;
    dayVal     = {2'b00, tensVal} * 6'd10 + {2'b00, day0Lat};
    latchedLen = monthLength(monthLat[2:0], leapLat);
    monthOk    = (monthLat >= 4'd1) && (monthLat <= 4'd4);
    day0Ok     = (day0Lat <= 4'd9);
    day1Ok     = (day1Lat <= 4'd3) || (day1Lat == BLANK_CODE);
    dateOk     = monthOk && day0Ok && day1Ok && (dayVal != 6'd0)
                 && (dayVal <= {1'b0, latchedLen});
    stepLen    = monthLength(m, leapLat);
    accTooBig  = (acc > 8'(MAX_NUMBER));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      monthLat <= 4'd0;
      day1Lat  <= 4'd0;
      day0Lat  <= 4'd0;
      leapLat  <= 1'b0;
      acc      <= 8'd0;
      m        <= 3'd0;
      number   <= 7'd0;
      error    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            monthLat <= month;
            day1Lat  <= day1;
            day0Lat  <= day0;
            leapLat  <= leap;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (dateOk) begin
            acc   <= {2'b00, dayVal};
            m     <= 3'd1;
            state <= ACCUM;
          end else begin
            number <= 7'd0;
            error  <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        ACCUM: begin
          if ({1'b0, m} != monthLat) begin
            acc <= acc + {3'b000, stepLen};
            m   <= m + 3'd1;
          end else begin
            number <= accTooBig ? 7'd0 : acc[6:0];
            error  <= accTooBig;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
